key_repeat_gen: RTL
===================

KEY_REPEAT_GEN -- requirements
Module: key_repeat_gen

Interface
REQ-001 SHALL have parameter N_KEYS, default 5: number of key lines (East, West, North, South, func_switch).
REQ-002 SHALL have parameter DELAY_CYC, default 25_000_000: cycles from first press pulse to first repeat pulse.
REQ-003 SHALL have parameter RATE_CYC, default 5_000_000: cycles between successive repeat pulses.
REQ-004 SHALL have port sysclk, input, 1: sole clock, all logic rising-edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port enable, input, 1: 1 means run, 0 means force IDLE.
REQ-007 SHALL have port keys_in, input, N_KEYS: debounced key levels, 1 means pressed.
REQ-008 SHALL have port key_pulse, output, N_KEYS: one-cycle press/repeat strobes to keyboard_proc.
REQ-009 SHALL have port key_held, output, N_KEYS: one-hot index of the tracked key, all zero when none.
REQ-010 SHALL have port repeat_active, output, 1: high while in REPEAT state.

Function
REQ-011 SHALL track at most one key; states IDLE, DELAY, REPEAT.
REQ-012 In IDLE with enable=1, SHALL select the lowest index i with keys_in[i]=1, then go to DELAY; key_pulse[i]=1 and key_held=1<<i are registered at that same edge.
REQ-013 All outputs SHALL be registered; key_pulse is never high for two consecutive cycles on the same bit.
REQ-014 DELAY SHALL count DELAY_CYC cycles; the edge DELAY_CYC cycles after the press pulse SHALL pulse key_pulse[i] again and enter REPEAT.
REQ-015 REPEAT SHALL pulse key_pulse[i] every RATE_CYC cycles while keys_in[i] stays 1.
REQ-016 Releasing the tracked key (keys_in[i]=0 sampled) in DELAY or REPEAT SHALL go to IDLE at that edge with no pulse; key_held and repeat_active clear at that edge.
REQ-017 Other keys pressed while a key is tracked SHALL be ignored; a still-held other key SHALL be accepted per REQ-012 at the edge after return to IDLE.
REQ-018 Release on the same edge as a terminal count SHALL take priority: no pulse.
REQ-019 enable=0 SHALL force IDLE at the next edge, clear counters, and suppress pulses; if a key is held when enable returns to 1, that key SHALL count as a new press.
REQ-020 The counter width SHALL be $clog2(max(DELAY_CYC,RATE_CYC)+1); it reloads on every state entry and never wraps.
REQ-021 DELAY_CYC and RATE_CYC below 2 SHALL be rejected by an elaboration-time check.

Reset
REQ-022 rst=0 SHALL asynchronously force IDLE, counter 0, key_pulse=0, key_held=0, repeat_active=0.
REQ-023 Reset deassertion with a key held SHALL count as a new press at the first enabled edge.

Configuration
REQ-024 With macro KEY_REPEAT_EN defined, SHALL behave per REQ-014 to REQ-015.
REQ-025 With KEY_REPEAT_EN undefined, SHALL emit only the press pulse and SHALL stay in DELAY without timing out until release; repeat_active is tied to 0 and the counter is not synthesized.

Structure
REQ-026 Package key_pkg SHALL hold the state enum (IDLE/DELAY/REPEAT) and the default N_KEYS, DELAY_CYC and RATE_CYC constants.
REQ-027 Sub-module key_repeat_timer SHALL contain the down-counter: load value, load strobe, terminal-count output.

Verification (bench DELAY_CYC=8, RATE_CYC=4)
REQ-028 Hold keys_in=00001 from cycle 0 -> key_pulse[0] at cycles 0, 8, 12, 16; repeat_active=1 from cycle 8.
REQ-029 Press key 2, release at cycle 5 -> one pulse only, key_held=0 from cycle 5.
REQ-030 keys_in=00110 on the same edge -> key_held=00010; release bit 1 at cycle 3 -> key_pulse[2] at cycle 4.
REQ-031 Release coincident with the cycle-8 terminal count -> no pulse at cycle 8, IDLE.
REQ-032 rst=0 mid-REPEAT, asynchronously between edges -> all outputs 0 immediately; rst=1 with key held -> new press pulse at the next edge.
REQ-033 KEY_REPEAT_EN undefined, key held 40 cycles -> exactly one pulse, repeat_active always 0.

Source files
------------

// File: rtl/key_pkg.sv
// Shared types and default constants for the key auto-repeat generator.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } key_state_e;

    localparam int unsigned KEY_N_KEYS    = 5;
    localparam int unsigned KEY_DELAY_CYC = 25_000_000;
    localparam int unsigned KEY_RATE_CYC  = 5_000_000;

    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/key_repeat_timer.sv
// Loadable down-counter; terminal count flags the edge on which the loaded interval expires.
module key_repeat_timer
    import key_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] count_q;

    // Saturates at zero so an unreloaded counter can never wrap into a fresh interval.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign tc_o = (count_q == CNT_W'(1));

endmodule

// File: rtl/key_repeat_gen.sv
// Single-key press/auto-repeat strobe generator.
// Repeat timing is built only when KEY_REPEAT_EN is defined; otherwise only the press pulse is emitted.
module key_repeat_gen
    import key_pkg::*;
#(
    parameter int unsigned N_KEYS    = KEY_N_KEYS,
    parameter int unsigned DELAY_CYC = KEY_DELAY_CYC,
    parameter int unsigned RATE_CYC  = KEY_RATE_CYC
) (
    input  logic              sysclk,
    input  logic              rst,
    input  logic              enable,
    input  logic [N_KEYS-1:0] keys_in,
    output logic [N_KEYS-1:0] key_pulse,
    output logic [N_KEYS-1:0] key_held,
    output logic              repeat_active
);

    if (DELAY_CYC < 2 || RATE_CYC < 2) begin : g_param_check
        $error("key_repeat_gen: DELAY_CYC and RATE_CYC must both be >= 2");
    end

    key_state_e        state_q;
    logic [N_KEYS-1:0] key_pulse_q;
    logic [N_KEYS-1:0] key_held_q;
    logic              repeat_q;

    logic [N_KEYS-1:0] press_oh;
    logic              held;
    logic              tc;

    // Isolate the lowest set bit: lowest-index key wins a simultaneous press.
    assign press_oh = keys_in & (~keys_in + 1'b1);
    assign held     = |(keys_in & key_held_q);

`ifdef KEY_REPEAT_EN
    localparam int unsigned CNT_W = cnt_width(DELAY_CYC, RATE_CYC);

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;

    // Reload on every state entry; loading zero in IDLE keeps the counter cleared.
    always_comb begin
        tmr_load = 1'b1;
        tmr_val  = '0;
        if (enable) begin
            unique case (state_q)
                IDLE: begin
                    if (|keys_in) tmr_val = CNT_W'(DELAY_CYC);
                end
                DELAY, REPEAT: begin
                    if (!held)   tmr_val  = '0;
                    else if (tc) tmr_val  = CNT_W'(RATE_CYC);
                    else         tmr_load = 1'b0;
                end
                default: tmr_val = '0;
            endcase
        end
    end

    key_repeat_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk_i     (sysclk),
        .rst_ni    (rst),
        .load_i    (tmr_load),
        .load_val_i(tmr_val),
        .tc_o      (tc)
    );
`else
    assign tc = 1'b0;
`endif

    always_ff @(posedge sysclk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            key_pulse_q <= '0;
            key_held_q  <= '0;
            repeat_q    <= 1'b0;
        end else begin
            key_pulse_q <= '0;
            if (!enable) begin
                state_q    <= IDLE;
                key_held_q <= '0;
                repeat_q   <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (|keys_in) begin
                            state_q     <= DELAY;
                            key_pulse_q <= press_oh;
                            key_held_q  <= press_oh;
                        end
                    end
                    // Release is tested before terminal count so it always suppresses the pulse.
                    DELAY: begin
                        if (!held) begin
                            state_q    <= IDLE;
                            key_held_q <= '0;
                        end else if (tc) begin
                            state_q     <= REPEAT;
                            key_pulse_q <= key_held_q;
                            repeat_q    <= 1'b1;
                        end
                    end
                    REPEAT: begin
                        if (!held) begin
                            state_q    <= IDLE;
                            key_held_q <= '0;
                            repeat_q   <= 1'b0;
                        end else if (tc) begin
                            key_pulse_q <= key_held_q;
                        end
                    end
                    default: begin
                        state_q    <= IDLE;
                        key_held_q <= '0;
                        repeat_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign key_pulse     = key_pulse_q;
    assign key_held      = key_held_q;
    assign repeat_active = repeat_q;

endmodule
